// File: rtl/alu_host_adapter.sv
// Host-side initiator for the chunked multi-cycle ALU: serializes a full-width
// request into operand beats, reassembles result beats, returns one response.
module alu_host_adapter #(
  parameter int unsigned OPERAND_BUS_WIDTH      = 8,
  parameter int unsigned OPERAND_MAX_DATA_WIDTH = 32,
  parameter int unsigned RESULT_BUS_WIDTH       = 16,
  parameter int unsigned RESULT_MAX_DATA_WIDTH  = 64,
  parameter int unsigned TIMEOUT_CYCLES         = 64
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  req_valid,
  output logic                                                  req_ready,
  input  logic [2:0]                                            req_op,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0]                     req_a,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0]                     req_b,
  output logic                                                  operand_valid,
  output logic [2:0]                                            op,
  output logic [OPERAND_BUS_WIDTH-1:0]                          a,
  output logic [OPERAND_BUS_WIDTH-1:0]                          b,
  output logic                                                  operand_last,
  input  logic                                                  ready,
  input  logic                                                  result_valid,
  input  logic [RESULT_BUS_WIDTH-1:0]                           result,
  input  logic                                                  result_last,
  input  logic                                                  result_rst,
  output logic                                                  rsp_valid,
  input  logic                                                  rsp_ready,
  output logic [RESULT_MAX_DATA_WIDTH-1:0]                      rsp_result,
  output logic [$clog2(RESULT_MAX_DATA_WIDTH/RESULT_BUS_WIDTH):0] rsp_beats,
  output logic                                                  rsp_err
);

  localparam int unsigned OP_BEATS  = OPERAND_MAX_DATA_WIDTH / OPERAND_BUS_WIDTH;
  localparam int unsigned RES_BEATS = RESULT_MAX_DATA_WIDTH / RESULT_BUS_WIDTH;
  localparam int unsigned IDX_W     = (OP_BEATS > 1) ? $clog2(OP_BEATS) : 1;
  localparam int unsigned CNT_W     = $clog2(RES_BEATS) + 1;
  localparam int unsigned WD_W      = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [1:0] {IDLE, SEND, COLLECT, RESPOND} state_t;

  state_t                            state_q, state_d;
  logic [OPERAND_MAX_DATA_WIDTH-1:0] a_q, b_q, ab_or;
  logic [IDX_W-1:0]                  beat_idx, last_idx, req_last;
  logic [WD_W-1:0]                   wd_q;
  logic                              wd_expired;

  // Last beat index is the highest non-zero operand chunk of either operand.
  always_comb begin
    ab_or    = req_a | req_b;
    req_last = '0;
    for (int unsigned i = 1; i < OP_BEATS; i++)
      if (ab_or[i*OPERAND_BUS_WIDTH +: OPERAND_BUS_WIDTH] != '0) req_last = IDX_W'(i);
  end

  always_comb wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SEND;
      SEND:    if (ready && (beat_idx == last_idx)) state_d = (op == OP_NOP) ? RESPOND : COLLECT;
      COLLECT: if (result_rst || (result_valid && result_last) || (!result_valid && wd_expired))
                 state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE) && rst;
    operand_valid = (state_q == SEND);
    operand_last  = (state_q == SEND) && (beat_idx == last_idx);
    rsp_valid     = (state_q == RESPOND);
    a = '0;
    b = '0;
    if (state_q == SEND) begin
      for (int unsigned i = 0; i < OP_BEATS; i++) begin
        if (beat_idx == IDX_W'(i)) begin
          a = a_q[i*OPERAND_BUS_WIDTH +: OPERAND_BUS_WIDTH];
          b = b_q[i*OPERAND_BUS_WIDTH +: OPERAND_BUS_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      beat_idx   <= '0;
      last_idx   <= '0;
      wd_q       <= '0;
      rsp_result <= '0;
      rsp_beats  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op         <= req_op;
          beat_idx   <= '0;
          rsp_result <= '0;
          rsp_beats  <= '0;
          rsp_err    <= 1'b0;
          // nop and reset carry no operand data: a single all-zero beat
          if (req_op == OP_NOP || req_op == OP_RST) begin
            a_q      <= '0;
            b_q      <= '0;
            last_idx <= '0;
          end else begin
            a_q      <= req_a;
            b_q      <= req_b;
            last_idx <= req_last;
          end
        end
        SEND: if (ready) begin
          beat_idx <= beat_idx + IDX_W'(1);
          wd_q     <= '0;
        end
        COLLECT: begin
          if (result_rst) begin
            if (op == OP_RST) begin
              rsp_result <= '0;
              rsp_err    <= 1'b0;
            end else begin
              rsp_err <= 1'b1;
            end
          end else if (result_valid) begin
            wd_q <= '0;
            if (rsp_beats < CNT_W'(RES_BEATS)) begin
              for (int unsigned i = 0; i < RES_BEATS; i++)
                if (rsp_beats == CNT_W'(i))
                  rsp_result[i*RESULT_BUS_WIDTH +: RESULT_BUS_WIDTH] <= result;
              rsp_beats <= rsp_beats + CNT_W'(1);
            end else begin
              rsp_err <= 1'b1;
            end
          end else if (wd_expired) begin
            rsp_err <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        RESPOND: if (rsp_ready) begin
          rsp_result <= '0;
          rsp_beats  <= '0;
          rsp_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_host_adapter.sv
// Scoreboard bench for alu_host_adapter: a reactive ALU model answers operand
// beats, a monitor checks responses and response timing against a reference.
module tb_alu_host_adapter;

  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_RSTP   = 2;
  localparam int M_NOP    = 3;
  localparam int M_OVF    = 4;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned n;
    int          mode;
    bit          stall2;
    bit          rnd_ready;
  } req_t;

  typedef struct {
    logic [63:0] result;
    logic [2:0]  beats;
    logic        err;
    bit          chk_beats;
  } rsp_t;

  typedef struct {
    logic [15:0] data;
    bit          last;
    bit          rstp;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        operand_valid, operand_last;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic        ready, result_valid, result_last, result_rst;
  logic [15:0] result;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic [2:0]  rsp_beats;
  logic        rsp_err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   force_rsp_ready = 1'b0;
  req_t op_exp[$];
  rsp_t exp_rsp[$];
  int   lat_q[$];

  alu_host_adapter #(
    .OPERAND_BUS_WIDTH(8), .OPERAND_MAX_DATA_WIDTH(32),
    .RESULT_BUS_WIDTH(16), .RESULT_MAX_DATA_WIDTH(64), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .operand_valid(operand_valid), .op(op), .a(a), .b(b), .operand_last(operand_last),
    .ready(ready), .result_valid(result_valid), .result(result),
    .result_last(result_last), .result_rst(result_rst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_beats(rsp_beats), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [63:0] alu_fn(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'b001:  return 64'(x) + 64'(y);
      3'b010:  return 64'(x & y);
      3'b011:  return 64'(x ^ y);
      3'b100:  return 64'(x) * 64'(y);
      default: return {x, y};
    endcase
  endfunction

  function automatic int unsigned res_beats(input logic [63:0] r);
    int unsigned n = 1;
    for (int i = 0; i < 4; i++) if (r[16*i +: 16] != 16'h0) n = i + 1;
    return n;
  endfunction

  function automatic int unsigned op_beats(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] v = x | y;
    int unsigned n = 1;
    for (int i = 0; i < 4; i++) if (v[8*i +: 8] != 8'h0) n = i + 1;
    return n;
  endfunction

  function automatic rsp_t ref_rsp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int mode);
    rsp_t r;
    r.result = '0; r.beats = '0; r.err = 1'b0; r.chk_beats = 1'b1;
    case (mode)
      M_NORMAL: begin r.result = alu_fn(o, x, y); r.beats = 3'(res_beats(r.result)); end
      M_OVF:    begin r.result = alu_fn(o, x, y); r.err = 1'b1; r.chk_beats = 1'b0; end
      M_RSTP:   r.err = (o != 3'b111);
      M_SILENT: r.err = 1'b1;
      default:  ;
    endcase
    return r;
  endfunction

  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int mode, input bit stall2, input bit rnd_ready);
    req_t t;
    int   w = 0;
    @(negedge clk);
    while (!req_ready && w < 2000) begin @(negedge clk); w++; end
    if (!req_ready) begin
      check("req_ready_wait", 64'(req_ready), 64'd1);
      return;
    end
    t.op = o;
    t.a = (o == 3'b000 || o == 3'b111) ? 32'h0 : x;
    t.b = (o == 3'b000 || o == 3'b111) ? 32'h0 : y;
    t.n = op_beats(t.a, t.b);
    t.mode = mode; t.stall2 = stall2; t.rnd_ready = rnd_ready;
    op_exp.push_back(t);
    exp_rsp.push_back(ref_rsp(o, x, y, mode));
    req_valid = 1'b1; req_op = o; req_a = x; req_b = y;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Reactive ALU: checks every presented operand beat, then answers per mode.
  initial begin : alu_model
    int unsigned cnt;
    int          stall_left;
    int          gap;
    logic [31:0] ra, rb;
    logic [63:0] r;
    req_t        t;
    beat_t       e, rq[$];
    int unsigned nb;
    cnt = 0; stall_left = 3; gap = 0; ra = '0; rb = '0;
    ready = 1'b0; result_valid = 1'b0; result_last = 1'b0; result_rst = 1'b0; result = '0;
    forever begin
      @(negedge clk);
      result_valid = 1'b0; result_last = 1'b0; result_rst = 1'b0; result = '0;
      if (!rst) begin
        ready = 1'b0; cnt = 0; stall_left = 3; gap = 0; ra = '0; rb = '0; rq.delete();
        continue;
      end
      if (rq.size() > 0) begin
        if (gap > 0) gap--;
        else if ($urandom_range(3, 0) != 0) begin
          e = rq.pop_front();
          if (e.rstp) result_rst = 1'b1;
          else begin result_valid = 1'b1; result = e.data; result_last = e.last; end
          if (rq.size() == 0) lat_q.push_back(cyc + 1);
        end
      end
      if (op_exp.size() == 0) ready = 1'($urandom_range(1, 0));
      else if (op_exp[0].stall2 && cnt == 2 && stall_left > 0) begin ready = 1'b0; stall_left--; end
      else if (op_exp[0].rnd_ready) ready = ($urandom_range(3, 0) != 0);
      else ready = 1'b1;
      if (operand_valid) begin
        if (op_exp.size() == 0) begin
          n_checks++;
          $display("FAIL operand_unexpected: got beat a=0x%0h b=0x%0h, expected none", a, b);
        end else begin
          t = op_exp[0];
          check("operand", 64'({op, operand_last, a, b}),
                64'({t.op, (cnt == t.n - 1), 8'(t.a >> (8*cnt)), 8'(t.b >> (8*cnt))}));
          if (ready) begin
            ra = ra | (32'(a) << (8*cnt));
            rb = rb | (32'(b) << (8*cnt));
            cnt++;
            if (operand_last) begin
              r = alu_fn(t.op, ra, rb);
              case (t.mode)
                M_NORMAL: begin
                  nb = res_beats(r);
                  for (int unsigned i = 0; i < nb; i++) begin
                    e.data = 16'(r >> (16*i)); e.last = (i == nb - 1); e.rstp = 1'b0;
                    rq.push_back(e);
                  end
                end
                M_OVF: begin
                  for (int unsigned i = 0; i < 4; i++) begin
                    e.data = 16'(r >> (16*i)); e.last = 1'b0; e.rstp = 1'b0;
                    rq.push_back(e);
                  end
                  e.data = 16'hDEAD; e.last = 1'b1; e.rstp = 1'b0;
                  rq.push_back(e);
                end
                M_RSTP: begin e.data = '0; e.last = 1'b0; e.rstp = 1'b1; rq.push_back(e); end
                M_SILENT: lat_q.push_back(cyc + 1 + 64);
                default:  lat_q.push_back(cyc + 1);
              endcase
              gap = $urandom_range(3, 0);
              void'(op_exp.pop_front());
              cnt = 0; ra = '0; rb = '0; stall_left = 3;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    bit   prev = 1'b0;
    rsp_t x;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !prev) begin
        if (lat_q.size() > 0) check("rsp_timing", 64'(cyc), 64'(lat_q.pop_front()));
        else begin
          n_checks++;
          $display("FAIL rsp_timing: got rsp_valid at cycle %0d, expected no response", cyc);
        end
      end
      prev = rsp_valid;
      rsp_ready = force_rsp_ready ? 1'b1 : ($urandom_range(2, 0) != 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: got result 0x%0h, expected no response", rsp_result);
        end else begin
          x = exp_rsp.pop_front();
          check("rsp_result", rsp_result, x.result);
          check("rsp_err", 64'(rsp_err), 64'(x.err));
          if (x.chk_beats) check("rsp_beats", 64'(rsp_beats), 64'(x.beats));
        end
      end
    end
  end

  initial begin : stimulus
    int          w;
    logic [2:0]  o;
    logic [31:0] x, y, m;
    int          md;
    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({req_ready, operand_valid, operand_last, rsp_valid, rsp_err, op, a, b, rsp_beats}), 64'd0);
    check("reset_rsp_result", rsp_result, 64'd0);
    #2 rst = 1'b1;
    #1 check("req_ready_after_release", 64'(req_ready), 64'd1);

    send(3'b001, 32'h0000_00FF, 32'h0000_0001, M_NORMAL, 1'b0, 1'b0);
    send(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, M_NORMAL, 1'b0, 1'b0);
    send(3'b011, 32'h1234_0000, 32'h0000_0000, M_NORMAL, 1'b1, 1'b0);
    send(3'b010, 32'hA5A5_1234, 32'h0F0F_00FF, M_SILENT, 1'b0, 1'b0);
    send(3'b111, 32'h0000_00AB, 32'h0000_CD00, M_RSTP, 1'b0, 1'b0);
    send(3'b000, 32'h0000_1234, 32'h0000_0005, M_NOP, 1'b0, 1'b0);
    send(3'b100, 32'h8000_0001, 32'h7FFF_FFFF, M_OVF, 1'b0, 1'b1);
    send(3'b011, 32'h0000_5555, 32'h0000_00AA, M_RSTP, 1'b0, 1'b1);
    send(3'b101, 32'h0102_0304, 32'h0506_0708, M_NORMAL, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(7, 0));
      case ($urandom_range(3, 0))
        0:       m = 32'h0000_00FF;
        1:       m = 32'h0000_FFFF;
        2:       m = 32'h00FF_FFFF;
        default: m = 32'hFFFF_FFFF;
      endcase
      x = $urandom & m;
      y = ($urandom_range(5, 0) == 0) ? 32'h0 : ($urandom & m);
      if (o == 3'b000)      md = M_NOP;
      else if (o == 3'b111) md = M_RSTP;
      else begin
        case ($urandom_range(19, 0))
          0:       md = M_OVF;
          1:       md = M_RSTP;
          default: md = M_NORMAL;
        endcase
      end
      send(o, x, y, md, 1'b0, 1'b1);
    end

    // Abort a multi-beat mul mid-transfer with an asynchronous reset.
    force_rsp_ready = 1'b1;
    send(3'b100, 32'hDEAD_BEEF, 32'h1234_5678, M_NORMAL, 1'b0, 1'b0);
    check("pre_reset_in_send", 64'(operand_valid), 64'd1);
    #2 rst = 1'b0;
    exp_rsp.delete(); op_exp.delete(); lat_q.delete();
    #1 check("reset_mid_send", 64'({operand_valid, req_ready, rsp_valid, a, b, op}), 64'd0);
    repeat (4) begin
      @(negedge clk);
      check("reset_held", 64'({operand_valid, rsp_valid, req_ready}), 64'd0);
    end
    #2 rst = 1'b1;
    force_rsp_ready = 1'b0;
    send(3'b001, 32'd2, 32'd3, M_NORMAL, 1'b0, 1'b0);

    w = 0;
    while (exp_rsp.size() != 0 && w < 3000) begin @(negedge clk); w++; end
    if (exp_rsp.size() != 0) check("drain_responses", 64'(exp_rsp.size()), 64'd0);
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
